// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite read arbiter.
// Response codes, master IDs and arbiter state encoding.
package axi_rd_arbiter_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way pick: a single requester always wins; on contention either
// fixed LSU priority or the round-robin pointer decides.
module axi_rd_arbiter_rr_arb2
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_M1 = 1
) (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = M_IFU;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = (PRIO_M1 != 0) ? M_LSU : ptr_i;
      (req_i == 2'b10): gnt_o = M_LSU;
      default:          gnt_o = M_IFU;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4-Lite AR/R port between IFU (m0) and LSU (m1).
// One read in flight; the grant is held from AR acceptance to R handshake.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRIO_M1 = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic              i_s_rvalid,
  output logic              o_s_rready
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              gnt;
  logic              own_rready;

  axi_rd_arbiter_rr_arb2 #(
    .PRIO_M1(PRIO_M1)
  ) u_pick (
    .req_i({i_m1_arvalid, i_m0_arvalid}),
    .ptr_i(rr_q),
    .gnt_o(gnt)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= M_IFU;
      rr_q      <= M_IFU;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign own_rready = owner_q ? i_m1_rready : i_m0_rready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m1_rdata   = '0;
    o_m0_rresp   = RRESP_OKAY;
    o_m1_rresp   = RRESP_OKAY;
    o_s_rready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          o_m0_arready = (gnt == M_IFU);
          o_m1_arready = (gnt == M_LSU);
          owner_d      = gnt;
          araddr_d     = gnt ? i_m1_araddr : i_m0_araddr;
          arvalid_d    = 1'b1;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        if (i_s_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        // Data path is a pure mux so the slave sees the owner's rready directly.
        o_s_rready = own_rready;
        if (owner_q == M_LSU) begin
          o_m1_rvalid = i_s_rvalid;
          o_m1_rdata  = i_s_rdata;
          o_m1_rresp  = i_s_rresp;
        end else begin
          o_m0_rvalid = i_s_rvalid;
          o_m0_rdata  = i_s_rdata;
          o_m0_rresp  = i_s_rresp;
        end
        if (i_s_rvalid && own_rready) begin
          rr_d    = ~owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_s_araddr  = araddr_q;
  assign o_s_arvalid = arvalid_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench: instance 0 is round-robin, instance 1 is fixed LSU priority.
// Directed reads pin behaviour, then random traffic runs against a model.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [31:0] m_addr [2][2];
  logic        m_arv  [2][2];
  logic        m_arr  [2][2];
  logic [31:0] m_rd   [2][2];
  logic [1:0]  m_rs   [2][2];
  logic        m_rv   [2][2];
  logic        m_rr   [2][2];
  logic [31:0] s_addr [2];
  logic        s_arv  [2];
  logic        s_arr  [2];
  logic [31:0] s_rd   [2];
  logic [1:0]  s_rs   [2];
  logic        s_rv   [2];
  logic        s_rr   [2];

  int n_chk = 0;
  int n_err = 0;
  bit rnd = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rd_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .PRIO_M1(g)
    ) u_dut (
      .i_clock     (clk),
      .i_reset     (rst[g]),
      .i_m0_araddr (m_addr[g][0]),
      .i_m0_arvalid(m_arv[g][0]),
      .o_m0_arready(m_arr[g][0]),
      .o_m0_rdata  (m_rd[g][0]),
      .o_m0_rresp  (m_rs[g][0]),
      .o_m0_rvalid (m_rv[g][0]),
      .i_m0_rready (m_rr[g][0]),
      .i_m1_araddr (m_addr[g][1]),
      .i_m1_arvalid(m_arv[g][1]),
      .o_m1_arready(m_arr[g][1]),
      .o_m1_rdata  (m_rd[g][1]),
      .o_m1_rresp  (m_rs[g][1]),
      .o_m1_rvalid (m_rv[g][1]),
      .i_m1_rready (m_rr[g][1]),
      .o_s_araddr  (s_addr[g]),
      .o_s_arvalid (s_arv[g]),
      .i_s_arready (s_arr[g]),
      .i_s_rdata   (s_rd[g]),
      .i_s_rresp   (s_rs[g]),
      .i_s_rvalid  (s_rv[g]),
      .o_s_rready  (s_rr[g])
    );
  end

  // model: phase 0 = waiting for a request, 1 = address out, 2 = data back
  int          ph  [2] = '{0, 0};
  int          own [2] = '{0, 0};
  int          rr  [2] = '{0, 0};
  logic [31:0] aq  [2] = '{32'h0, 32'h0};
  logic [31:0] ea  [2][2];
  int          n_rd [2] = '{0, 0};
  logic        hs_ar [2][2];
  logic        hs_r  [2][2];
  logic        hs_sar [2];
  logic        hs_sr  [2];

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC3C3_A5A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    chk(nm, {31'b0, a}, {31'b0, e});
  endtask

  task automatic chk2(input string nm, input logic [1:0] a,
                      input logic [1:0] e);
    chk(nm, {30'b0, a}, {30'b0, e});
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic any;
      logic sel;
      int   win;
      any = m_arv[k][0] || m_arv[k][1];
      if (m_arv[k][0] && m_arv[k][1]) win = (k == 1) ? 1 : rr[k];
      else win = m_arv[k][1] ? 1 : 0;
      if (!rst[k]) begin
        for (int j = 0; j < 2; j++) begin
          sel = (ph[k] == 2) && (own[k] == j);
          chk1($sformatf("k%0d_m%0d_arready", k, j), m_arr[k][j],
               ph[k] == 0 && any && win == j);
          chk1($sformatf("k%0d_m%0d_rvalid", k, j), m_rv[k][j],
               sel ? s_rv[k] : 1'b0);
          chk($sformatf("k%0d_m%0d_rdata", k, j), m_rd[k][j],
              sel ? s_rd[k] : 32'h0);
          chk2($sformatf("k%0d_m%0d_rresp", k, j), m_rs[k][j],
               sel ? s_rs[k] : 2'b00);
          if (rnd && m_rv[k][j] && m_rr[k][j]) begin
            chk($sformatf("k%0d_m%0d_e2e", k, j), m_rd[k][j],
                f(ea[k][j]));
            n_rd[k]++;
          end
          if (m_arv[k][j] && m_arr[k][j]) ea[k][j] = m_addr[k][j];
        end
        chk1($sformatf("k%0d_s_arvalid", k), s_arv[k], ph[k] == 1);
        chk($sformatf("k%0d_s_araddr", k), s_addr[k], aq[k]);
        chk1($sformatf("k%0d_s_rready", k), s_rr[k],
             ph[k] == 2 && m_rr[k][own[k]]);
      end
      for (int j = 0; j < 2; j++) begin
        hs_ar[k][j] = m_arv[k][j] && m_arr[k][j];
        hs_r[k][j]  = m_rv[k][j] && m_rr[k][j];
      end
      hs_sar[k] = s_arv[k] && s_arr[k];
      hs_sr[k]  = s_rv[k] && s_rr[k];
      if (rst[k]) begin
        ph[k] = 0; own[k] = 0; rr[k] = 0; aq[k] = 32'h0;
      end else if (ph[k] == 0) begin
        if (any) begin
          own[k] = win; aq[k] = m_addr[k][win]; ph[k] = 1;
        end
      end else if (ph[k] == 1) begin
        if (s_arr[k]) ph[k] = 2;
      end else if (s_rv[k] && m_rr[k][own[k]]) begin
        ph[k] = 0; rr[k] = 1 - own[k];
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    model_step();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int k);
    for (int j = 0; j < 2; j++) begin
      m_arv[k][j] = 0; m_addr[k][j] = 0; m_rr[k][j] = 0;
    end
    s_arr[k] = 0; s_rv[k] = 0; s_rd[k] = 0; s_rs[k] = 0;
  endtask

  task automatic chk_rst(input int k);
    chk1("rst_s_arvalid", s_arv[k], 1'b0);
    chk("rst_s_araddr", s_addr[k], 32'h0);
    chk1("rst_s_rready", s_rr[k], 1'b0);
    for (int j = 0; j < 2; j++) begin
      chk1("rst_arready", m_arr[k][j], 1'b0);
      chk1("rst_rvalid", m_rv[k][j], 1'b0);
      chk("rst_rdata", m_rd[k][j], 32'h0);
      chk2("rst_rresp", m_rs[k][j], 2'b00);
    end
  endtask

  task automatic rst_pulse(input int k);
    clr(k);
    rst[k] = 1;
    neg(); nxt();
    rst[k] = 0;
    neg(); chk_rst(k); nxt();
  endtask

  task automatic rd(input int k, input int j, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] rs,
                    input int arw, input int rw);
    int got = 0;
    m_arv[k][j] = 1; m_addr[k][j] = a;
    neg(); chk1("rd_arready", m_arr[k][j], 1'b1); nxt();
    m_arv[k][j] = 0;
    for (int i = 0; i <= arw; i++) begin
      s_arr[k] = (i == arw);
      neg();
      chk1("rd_s_arvalid", s_arv[k], 1'b1);
      chk("rd_s_araddr", s_addr[k], a);
      nxt();
    end
    s_arr[k] = 0; s_rv[k] = 1; s_rd[k] = d; s_rs[k] = rs;
    for (int i = 0; i <= rw; i++) begin
      m_rr[k][j] = (i == rw);
      neg();
      chk1("rd_rvalid", m_rv[k][j], 1'b1);
      chk("rd_rdata", m_rd[k][j], d);
      chk2("rd_rresp", m_rs[k][j], rs);
      chk1("rd_other_rvalid", m_rv[k][1-j], 1'b0);
      chk1("rd_s_arvalid_low", s_arv[k], 1'b0);
      chk1("rd_s_rready", s_rr[k], i == rw);
      if (m_rv[k][j] && m_rr[k][j]) got++;
      nxt();
    end
    s_rv[k] = 0; m_rr[k][j] = 0;
    neg();
    chk1("rd_rvalid_done", m_rv[k][j], 1'b0);
    chk("rd_once", got, 32'd1);
    nxt();
  endtask

  bit   wt  [2][2];
  bit   busy [2];
  bit   sp  [2];
  int   lat [2];

  task automatic drive_rand(input int k);
    logic [31:0] r;
    if (rst[k]) begin
      clr(k);
      busy[k] = 0; sp[k] = 0; wt[k][0] = 0; wt[k][1] = 0;
      rst[k] = 0;
      return;
    end
    for (int j = 0; j < 2; j++) begin
      if (m_arv[k][j] && hs_ar[k][j]) begin
        m_arv[k][j] = 0; wt[k][j] = 1;
      end
      if (hs_r[k][j]) wt[k][j] = 0;
      if (!m_arv[k][j] && !wt[k][j] && $urandom_range(0, 2) == 0) begin
        r = $urandom;
        m_arv[k][j] = 1; m_addr[k][j] = {r[31:2], 2'b00};
      end
      m_rr[k][j] = $urandom_range(0, 3) != 0;
    end
    if (sp[k]) begin
      s_rv[k] = 0; sp[k] = 0;
    end
    if (hs_sar[k]) begin
      busy[k] = 1; lat[k] = $urandom_range(0, 2);
    end
    if (busy[k] && s_rv[k] && hs_sr[k]) begin
      busy[k] = 0; s_rv[k] = 0;
    end
    if (busy[k] && !s_rv[k]) begin
      if (lat[k] == 0) begin
        s_rv[k] = 1; s_rd[k] = f(s_addr[k]);
        s_rs[k] = 2'($urandom_range(0, 3));
      end else lat[k]--;
    end
    if (!busy[k] && !s_rv[k] && $urandom_range(0, 15) == 0) begin
      s_rv[k] = 1; sp[k] = 1; s_rd[k] = $urandom;
    end
    s_arr[k] = !busy[k] && ($urandom_range(0, 1) == 1);
    rst[k] = $urandom_range(0, 399) == 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    for (int k = 0; k < 2; k++) begin
      clr(k); rst[k] = 1;
    end
    nxt();
    rst_pulse(0);
    rst_pulse(1);

    rd(1, 0, 32'h8000_0000, 32'h0000_0413, RRESP_OKAY, 0, 0);

    rst_pulse(1);
    m_arv[1][0] = 1; m_addr[1][0] = 32'h8000_0010;
    m_arv[1][1] = 1; m_addr[1][1] = 32'hA000_0000;
    m_rr[1][0] = 1; m_rr[1][1] = 1;
    s_arr[1] = 1; s_rv[1] = 1; s_rd[1] = 32'h11;
    neg();
    chk1("prio_m1_arready", m_arr[1][1], 1'b1);
    chk1("prio_m0_arready", m_arr[1][0], 1'b0);
    nxt(); m_arv[1][1] = 0;
    neg();
    chk("prio_addr1", s_addr[1], 32'hA000_0000);
    chk1("prio_m0_held", m_arr[1][0], 1'b0);
    nxt();
    neg(); chk1("prio_m1_rvalid", m_rv[1][1], 1'b1); nxt();
    neg(); chk1("prio_m0_next", m_arr[1][0], 1'b1); nxt();
    m_arv[1][0] = 0;
    neg(); chk("prio_addr0", s_addr[1], 32'h8000_0010); nxt();
    neg(); chk1("prio_m0_rvalid", m_rv[1][0], 1'b1); nxt();
    clr(1);

    rst_pulse(0);
    m_arv[0][0] = 1; m_addr[0][0] = 32'h0000_00A0;
    m_arv[0][1] = 1; m_addr[0][1] = 32'h0000_00A4;
    m_rr[0][0] = 1; m_rr[0][1] = 1;
    s_arr[0] = 1; s_rv[0] = 1; s_rd[0] = 32'h22;
    for (int c = 0; c < 12; c++) begin
      neg();
      if (m_arr[0][0]) gq.push_back(0);
      if (m_arr[0][1]) gq.push_back(1);
      nxt();
    end
    clr(0);
    chk("rr_count", gq.size(), 32'd4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      chk($sformatf("rr_order%0d", i), gq[i], i % 2);

    rst_pulse(0);
    rd(0, 0, 32'h2000_0040, 32'hDEAD_BEEF, RRESP_OKAY, 3, 2);

    rd(1, 1, 32'h3000_0000, 32'h0000_CAFE, RRESP_SLVERR, 0, 0);
    rd(1, 0, 32'h3000_0008, 32'h0000_0077, RRESP_OKAY, 1, 0);

    rst_pulse(1);
    m_arv[1][0] = 1; m_addr[1][0] = 32'h0000_0100;
    neg(); nxt();
    m_arv[1][0] = 0; s_arr[1] = 1;
    neg(); nxt();
    s_arr[1] = 0; s_rv[1] = 1; s_rd[1] = 32'h55; m_rr[1][0] = 0;
    neg(); chk1("mid_rvalid", m_rv[1][0], 1'b1); nxt();
    rst[1] = 1; s_rv[1] = 0;
    neg(); nxt();
    rst[1] = 0;
    neg(); chk_rst(1); nxt();
    rd(1, 1, 32'h0000_0004, 32'h0000_1234, RRESP_OKAY, 0, 0);

    rst_pulse(0);
    rst_pulse(1);
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; sp[k] = 0; lat[k] = 0;
      wt[k][0] = 0; wt[k][1] = 0;
    end
    rnd = 1;
    for (int c = 0; c < 4000; c++) begin
      neg();
      nxt();
      drive_rand(0);
      drive_rand(1);
    end
    chk1("rand_reads0", n_rd[0] > 100, 1'b1);
    chk1("rand_reads1", n_rd[1] > 100, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4-Lite read port (AR/R channels) between two requesters: m0 = IFU instruction fetch, m1 = LSU loads.
- Write channels (AW/W/B) do not pass through this block; LSU writes go straight to the slave.
- Exactly one read is outstanding at a time. The grant is held from AR acceptance until the R handshake completes.
- Sits between the IFU/LSU read masters and the memory/crossbar read slave.

Parameters:
- ADDR_W, 32, address width of all AR channels.
- DATA_W, 32, data width of all R channels.
- PRIO_M1, 1: 1 = m1 (LSU) wins on contention (fixed priority); 0 = round-robin.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_m0_araddr  in  ADDR_W  IFU read address
- i_m0_arvalid  in  1  IFU address valid
- o_m0_arready  out  1  IFU address accepted
- o_m0_rdata  out  DATA_W  IFU read data
- o_m0_rresp  out  2  IFU read response
- o_m0_rvalid  out  1  IFU data valid
- i_m0_rready  in  1  IFU data ready
- i_m1_araddr  in  ADDR_W  LSU read address
- i_m1_arvalid  in  1  LSU address valid
- o_m1_arready  out  1  LSU address accepted
- o_m1_rdata  out  DATA_W  LSU read data
- o_m1_rresp  out  2  LSU read response
- o_m1_rvalid  out  1  LSU data valid
- i_m1_rready  in  1  LSU data ready
- o_s_araddr  out  ADDR_W  slave read address (registered)
- o_s_arvalid  out  1  slave address valid (registered)
- i_s_arready  in  1  slave address ready
- i_s_rdata  in  DATA_W  slave read data
- i_s_rresp  in  2  slave read response
- i_s_rvalid  in  1  slave data valid
- o_s_rready  out  1  slave data ready

Behaviour:
- One clock, i_clock. Reset i_reset is synchronous and active-high.
- Reset values:
  - state = IDLE; owner = m0; rr_next = m0.
  - o_s_arvalid = 0, o_s_araddr = 0.
  - All o_mX_arready, o_mX_rvalid and o_s_rready = 0.
  - o_mX_rdata = 0, o_mX_rresp = 0.
- FSM states: IDLE, AR, R.
- IDLE:
  - Winner selection:
    - Only one arvalid high: that master wins.
    - Both high and PRIO_M1=1: m1 wins.
    - Both high and PRIO_M1=0: rr_next wins.
  - o_mW_arready = 1 combinationally in the same cycle (AR handshake with the master).
  - On that edge: latch owner = W and o_s_araddr = i_mW_araddr; set o_s_arvalid = 1; go to AR.
  - Loser's arready stays 0; its request stays pending.
- AR:
  - Hold o_s_arvalid = 1 and the address until i_s_arready.
  - On i_s_arready: o_s_arvalid <= 0, go to R.
  - Minimum one cycle in AR.
- R (combinational routing):
  - o_owner_rvalid = i_s_rvalid; o_owner_rdata = i_s_rdata; o_owner_rresp = i_s_rresp; o_s_rready = i_owner_rready.
  - On i_s_rvalid && o_s_rready: go to IDLE; rr_next = the non-owner.
- Non-owner master: rvalid/rdata/rresp = 0 in every state.
- In IDLE and AR: o_s_rready = 0.
- Latency:
  - Master AR handshake to o_s_arvalid: 1 cycle.
  - R handshake to next grant: 1 cycle (IDLE re-arbitrates in the cycle after R completes).
  - Back-to-back reads: at least 3 cycles each with a zero-wait slave.
- Boundary conditions:
  - Owner rready low: stay in R, slave data held by the slave.
  - rresp != OKAY: forwarded unchanged to the owner; no retry.
  - New arvalid during AR/R: ignored until IDLE.
  - Reset mid-transaction: return to IDLE immediately; the in-flight response is dropped. The slave is reset with the same i_reset.
  - i_s_rvalid in IDLE/AR: protocol violation, ignored (rready = 0).
- Round-robin pointer updates only on a completed R handshake.

Decomposition:
- Shared package: RRESP_OKAY/EXOKAY/SLVERR/DECERR constants; arbiter state enum; master-ID constants M_IFU=0, M_LSU=1.
- One natural sub-module: rr_arb2, a 2-way priority/round-robin pick with pointer input. All else inline.

Test Plan:
- m0 only, araddr=0x8000_0000, slave arready and rvalid each 1 cycle later with rdata=0x0000_0413 → m0 receives 0x0000_0413 with rresp=0; o_s_arvalid high exactly 1 cycle; m1 sees no rvalid.
- Both arvalid in the same cycle, PRIO_M1=1, m0 addr 0x8000_0010, m1 addr 0xA000_0000 → m1 granted first and slave sees 0xA000_0000; m0 served next at 0x8000_0010.
- PRIO_M1=0, both requesting continuously for 4 reads → grant order m0, m1, m0, m1.
- Slave arready delayed 3 cycles, owner rready low for 2 cycles after rvalid → o_s_arvalid and address stable 4 cycles; state stays R until rready; data 0xDEAD_BEEF delivered once.
- Slave returns rresp=2'b10 (SLVERR) to m1 → m1 sees rresp=2'b10; arbiter returns to IDLE and serves the next request normally.
- i_reset asserted while in R with m0 owner → next cycle all outputs at reset values; a subsequent m1 read of 0x0000_0004 completes correctly.
